// File: rtl/animator_pkg.sv
// Shared types and helpers for the multi-cursor animator.
package animator_pkg;

  typedef enum logic [1:0] {
    ModeWrap   = 2'd0,
    ModeBounce = 2'd1,
    ModeKey    = 2'd2,
    ModeHold   = 2'd3
  } mode_t;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_t;

  localparam int unsigned PosFlatW = 16;

  function automatic int unsigned axis_limit(input bit is_x, input int unsigned sw,
                                             input int unsigned sh);
    return is_x ? sw : sh;
  endfunction

endpackage

// File: rtl/animator_channel.sv
// One cursor: position and bounce direction, updated only on tick.
module animator_channel
  import animator_pkg::*;
#(
  parameter int unsigned limit  = 640,
  parameter int unsigned w_pos  = 10,
  parameter int unsigned w_step = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  input  mode_t             i_mode,
  input  logic [w_step-1:0] i_step,
  input  logic              i_key_inc,
  input  logic              i_key_dec,
  output logic [w_pos-1:0]  o_pos
);

  // Headroom so p+s and 2(L-1) never wrap.
  localparam int unsigned WE = ((w_pos > w_step) ? w_pos : w_step) + 2;
  localparam logic [WE-1:0] Lim  = WE'(limit);
  localparam logic [WE-1:0] Lim1 = WE'(limit - 1);
  localparam logic [WE-1:0] Lim2 = WE'(2 * (limit - 1));

  logic [w_pos-1:0] r_pos;
  dir_t             r_dir;
  logic [w_pos-1:0] w_nxt;
  dir_t             w_dir_d;
  logic [WE-1:0]    w_cur, w_s, w_sum;

  always_comb begin
    w_cur   = WE'(r_pos);
    w_s     = WE'(i_step);
    w_sum   = w_cur + w_s;
    w_nxt   = r_pos;
    w_dir_d = r_dir;
    unique case (i_mode)
      ModeWrap: w_nxt = (w_sum <= Lim1) ? w_pos'(w_sum) : w_pos'(w_sum - Lim);
      ModeBounce: begin
        if (r_dir == DirUp) begin
          if (w_sum <= Lim1) begin
            w_nxt = w_pos'(w_sum);
          end else begin
            w_nxt   = w_pos'(Lim2 - w_sum);
            w_dir_d = DirDown;
          end
        end else if (w_cur >= w_s) begin
          w_nxt = w_pos'(w_cur - w_s);
        end else begin
          w_nxt   = w_pos'(w_s - w_cur);
          w_dir_d = DirUp;
        end
      end
      ModeKey: begin
        if (i_key_inc && !i_key_dec) begin
          w_nxt = (w_sum <= Lim1) ? w_pos'(w_sum) : w_pos'(Lim1);
        end else if (i_key_dec && !i_key_inc) begin
          w_nxt = (w_cur >= w_s) ? w_pos'(w_cur - w_s) : '0;
        end
      end
      ModeHold: w_nxt = r_pos;
      default:  w_nxt = r_pos;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos <= w_pos'(limit / 2);
      r_dir <= DirUp;
    end else if (i_tick) begin
      r_pos <= w_nxt;
      r_dir <= w_dir_d;
    end
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/multi_cursor_animator.sv
// Top: tick prescaler, per-channel cursors, hit compare, colour OR and RGB registers.
module multi_cursor_animator
  import animator_pkg::*;
#(
  parameter int unsigned       n_ch          = 2,
  parameter int unsigned       screen_width  = 640,
  parameter int unsigned       screen_height = 480,
  parameter int unsigned       w_x           = $clog2(screen_width),
  parameter int unsigned       w_y           = $clog2(screen_height),
  parameter int unsigned       w_div         = 20,
  parameter int unsigned       w_step        = 4,
  parameter logic [n_ch-1:0]   axis_mask     = 'b01,
  parameter logic [3*n_ch-1:0] ch_color      = 'o42,
  parameter int unsigned       w_red         = 4,
  parameter int unsigned       w_green       = 4,
  parameter int unsigned       w_blue        = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [2*n_ch-1:0]          i_mode,
  input  logic [w_step*n_ch-1:0]     i_step,
  input  logic [n_ch-1:0]            i_key_inc,
  input  logic [n_ch-1:0]            i_key_dec,
  input  logic [w_x-1:0]             i_x,
  input  logic [w_y-1:0]             i_y,
  output logic [w_red-1:0]           o_red,
  output logic [w_green-1:0]         o_green,
  output logic [w_blue-1:0]          o_blue,
  output logic                       o_tick,
  output logic [PosFlatW*n_ch-1:0]   o_pos_flat
);

  logic [w_div-1:0]    r_div;
  logic                r_tick;
  logic [w_red-1:0]    r_red;
  logic [w_green-1:0]  r_green;
  logic [w_blue-1:0]   r_blue;
  logic [PosFlatW-1:0] w_pos_arr [n_ch];
  logic [n_ch-1:0]     w_hit;
  logic [2:0]          w_rgb_any;

  for (genvar i = 0; i < n_ch; i++) begin : g_ch
    localparam int unsigned Lim  = axis_limit(axis_mask[i], screen_width, screen_height);
    localparam int unsigned WPos = axis_mask[i] ? w_x : w_y;
    logic [WPos-1:0] w_ch_pos;

    animator_channel #(
      .limit  (Lim),
      .w_pos  (WPos),
      .w_step (w_step)
    ) u_channel (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_tick    (r_tick),
      .i_mode    (mode_t'(i_mode[2*i +: 2])),
      .i_step    (i_step[w_step*i +: w_step]),
      .i_key_inc (i_key_inc[i]),
      .i_key_dec (i_key_dec[i]),
      .o_pos     (w_ch_pos)
    );

    assign w_pos_arr[i] = PosFlatW'(w_ch_pos);
    assign o_pos_flat[PosFlatW*i +: PosFlatW] = w_pos_arr[i];

    if (axis_mask[i]) begin : g_x
      assign w_hit[i] = PosFlatW'(i_x) > w_pos_arr[i];
    end else begin : g_y
      assign w_hit[i] = PosFlatW'(i_y) > w_pos_arr[i];
    end
  end

  always_comb begin
    w_rgb_any = '0;
    for (int i = 0; i < n_ch; i++) begin
      if (w_hit[i]) w_rgb_any = w_rgb_any | ch_color[3*i +: 3];
    end
  end

  // Tick is high the cycle after the prescaler wraps from all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div   <= '0;
      r_tick  <= 1'b0;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_div   <= r_div + 1'b1;
      r_tick  <= &r_div;
      r_red   <= {w_red{w_rgb_any[2]}};
      r_green <= {w_green{w_rgb_any[1]}};
      r_blue  <= {w_blue{w_rgb_any[0]}};
    end
  end

  assign o_tick  = r_tick;
  assign o_red   = r_red;
  assign o_green = r_green;
  assign o_blue  = r_blue;

endmodule

// File: tb/tb_multi_cursor_animator.sv
// Randomised and directed bench for multi_cursor_animator against a behavioural model.
module tb_multi_cursor_animator;

  localparam int NCh     = 2;
  localparam int WDiv    = 2;
  localparam int TickPer = 1 << WDiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  mode = '1;
  logic [7:0]  step = '0;
  logic [1:0]  key_inc = '0, key_dec = '0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic [3:0]  red, green, blue;
  logic        tick;
  logic [31:0] pos_flat;

  multi_cursor_animator #(.n_ch(NCh), .w_div(WDiv)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_mode     (mode),
    .i_step     (step),
    .i_key_inc  (key_inc),
    .i_key_dec  (key_dec),
    .i_x        (x),
    .i_y        (y),
    .o_red      (red),
    .o_green    (green),
    .o_blue     (blue),
    .o_tick     (tick),
    .o_pos_flat (pos_flat)
  );

  always #5 clk = ~clk;

  // ch0 moves on X (640) and is green; ch1 moves on Y (480) and is red.
  int lim [NCh] = '{640, 480};
  int colr[NCh] = '{3'b010, 3'b100};
  int m_pos[NCh];
  int m_up [NCh];
  int m_cyc;
  bit m_tick;
  logic [2:0] m_rgb;
  int n_tests = 0, n_fail = 0;

  function automatic logic [31:0] exp_flat();
    return {16'(m_pos[1]), 16'(m_pos[0])};
  endfunction

  task automatic model_reset();
    m_pos[0] = 320; m_pos[1] = 240;
    m_up[0] = 1; m_up[1] = 1;
    m_cyc = 0; m_tick = 0; m_rgb = '0;
  endtask

  function automatic void model_move();
    for (int c = 0; c < NCh; c++) begin
      int p, s, l, md;
      p = m_pos[c]; s = int'(step[4*c +: 4]); l = lim[c]; md = int'(mode[2*c +: 2]);
      case (md)
        0: p = (p + s < l) ? p + s : p + s - l;
        1: if (m_up[c] == 1) begin
             if (p + s < l) p = p + s;
             else begin p = 2 * (l - 1) - (p + s); m_up[c] = 0; end
           end else begin
             if (p >= s) p = p - s;
             else begin p = s - p; m_up[c] = 1; end
           end
        2: if (key_inc[c] && !key_dec[c]) p = (p + s > l - 1) ? l - 1 : p + s;
           else if (key_dec[c] && !key_inc[c]) p = (p - s < 0) ? 0 : p - s;
        default: ;
      endcase
      m_pos[c] = p;
    end
  endfunction

  // Advance one clock: model follows the edge, then return 1 time unit after it.
  task automatic adv();
    logic [2:0] rgb;
    @(posedge clk);
    rgb = '0;
    if (int'(x) > m_pos[0]) rgb = rgb | 3'(colr[0]);
    if (int'(y) > m_pos[1]) rgb = rgb | 3'(colr[1]);
    m_rgb = rgb;
    if (m_tick) model_move();
    m_cyc++;
    m_tick = (m_cyc % TickPer == 0);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode = '1; x = 10'd639; y = 9'd479;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({red, green, blue, tick} !== 13'd0 || pos_flat !== 32'h00F0_0140) begin
      n_fail++;
      $display("FAIL reset_hold: rgbt=%h pos=%h expected 0 / 00f00140", {red, green, blue, tick},
               pos_flat);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      adv();
      n_tests++;
      if (tick !== m_tick) begin
        n_fail++;
        $display("FAIL reset_tick cyc%0d: tick=%b expected %b", i, tick, m_tick);
      end
    end
    n_tests++;
    if (pos_flat !== exp_flat()) begin
      n_fail++;
      $display("FAIL reset_pos: %h expected %h", pos_flat, exp_flat());
    end
  endtask

  task automatic run_checked(input string name, input int cycles, input bit rnd_mode,
                             input bit rnd_step);
    for (int i = 0; i < cycles; i++) begin
      if (rnd_mode) mode = 4'($urandom);
      if (rnd_step) step = 8'($urandom);
      if (rnd_mode) begin key_inc = 2'($urandom); key_dec = 2'($urandom); end
      x = 10'($urandom_range(0, 700));
      y = 9'($urandom_range(0, 511));
      adv();
      n_tests++;
      if (pos_flat !== exp_flat() || tick !== m_tick ||
          red !== {4{m_rgb[2]}} || green !== {4{m_rgb[1]}} || blue !== {4{m_rgb[0]}}) begin
        n_fail++;
        $display("FAIL %s cyc%0d: pos=%h tick=%b rgb=%h%h%h expected pos=%h tick=%b rgb=%b", name,
                 m_cyc, pos_flat, tick, red, green, blue, exp_flat(), m_tick, m_rgb);
      end
    end
  endtask

  task automatic test_pixel();
    mode = '1;
    step = '0;
    for (int i = 0; i < 4; i++) begin
      logic [9:0] xs [4] = '{10'd321, 10'd321, 10'd320, 10'd639};
      logic [8:0] ys [4] = '{9'd100, 9'd241, 9'd240, 9'd479};
      x = xs[i]; y = ys[i];
      adv();
      n_tests++;
      if (red !== {4{m_rgb[2]}} || green !== {4{m_rgb[1]}} || blue !== {4{m_rgb[0]}}) begin
        n_fail++;
        $display("FAIL pixel_%0d: rgb=%h%h%h expected %b", i, red, green, blue, m_rgb);
      end
    end
  endtask

  task automatic test_wrap();
    mode = 4'b0000; step = 8'hFF;
    run_checked("wrap", 480, 0, 0);
    step = 8'h5D;
    run_checked("wrap_odd", 200, 0, 0);
  endtask

  task automatic test_bounce();
    mode = 4'b0101; step = 8'hFD;
    run_checked("bounce", 600, 0, 0);
    step = 8'h4E;
    run_checked("bounce2", 400, 0, 0);
  endtask

  task automatic test_key();
    mode = 4'b1010; step = 8'hFF;
    key_inc = 2'b11; key_dec = 2'b00;
    run_checked("key_inc_sat", 200, 0, 0);
    key_dec = 2'b11;
    run_checked("key_both", 16, 0, 0);
    key_inc = 2'b00;
    run_checked("key_dec_sat", 300, 0, 0);
  endtask

  task automatic test_random();
    run_checked("random", 2000, 1, 1);
  endtask

  task automatic test_reset_midrun();
    while (!m_tick) adv();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({red, green, blue, tick} !== 13'd0 || pos_flat !== exp_flat()) begin
      n_fail++;
      $display("FAIL midrun_reset: rgbt=%h pos=%h expected 0 / %h", {red, green, blue, tick},
               pos_flat, exp_flat());
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    mode = 4'b0000; step = 8'h33;
    run_checked("after_reset", 40, 0, 0);
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_wrap();
    test_bounce();
    test_key();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
